// File: rtl/potato1_pkg.sv
// Potato-1 control unit shared definitions: opcodes, pc-control codes, strobe indices, FSM states.
// The HALT state exists only when POTATO1_HALT_EN is defined.
package potato1_pkg;

  localparam int DEPTH_W_DEF = 4;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_PINC   = 4'h1;
  localparam logic [3:0] OP_PDEC   = 4'h2;
  localparam logic [3:0] OP_DINC   = 4'h3;
  localparam logic [3:0] OP_DDEC   = 4'h4;
  localparam logic [3:0] OP_OUT    = 4'h5;
  localparam logic [3:0] OP_IN     = 4'h6;
  localparam logic [3:0] OP_LOPEN  = 4'h7;
  localparam logic [3:0] OP_LCLOSE = 4'h8;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_DEC  = 2'b10;
  localparam logic [1:0] PC_CLR  = 2'b11;

  localparam int CMD_PINC = 0;
  localparam int CMD_PDEC = 1;
  localparam int CMD_DINC = 2;
  localparam int CMD_DDEC = 3;
  localparam int CMD_OUT  = 4;
  localparam int CMD_IN   = 5;
  localparam int CMD_W    = 6;

  typedef enum logic [1:0] {
    ST_EXEC      = 2'd0,
    ST_SKIP_FWD  = 2'd1,
    ST_SKIP_BACK = 2'd2
`ifdef POTATO1_HALT_EN
    , ST_HALT    = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    DEP_HOLD = 2'd0,
    DEP_CLR  = 2'd1,
    DEP_INC  = 2'd2,
    DEP_DEC  = 2'd3
  } dep_act_t;

endpackage

// File: rtl/potato1_if.sv
// Control-unit bus: opcode and datapath feedback in, pc control and command strobes out.
interface potato1_if;
  logic [3:0] instr;
  logic       zeroflag;
  logic       ioready;
  logic [1:0] pc;
  logic [5:0] cmd;

  modport master (output instr, zeroflag, ioready, input pc, cmd);
  modport slave  (input instr, zeroflag, ioready, output pc, cmd);
endinterface

// File: rtl/potato1_decoder.sv
// Combinational Potato-1 sequencing: (state, opcode, flags, depth==0) -> pc, strobes, next state, depth action.
// Opcode F enters HALT only when POTATO1_HALT_EN is defined.
module potato1_decoder
  import potato1_pkg::*;
(
  input  state_t          i_state,
  input  logic            i_depth_zero,
  potato1_if.slave        bus,
  output state_t          o_next,
  output dep_act_t        o_dact
);

  always_comb begin
    bus.pc  = PC_HOLD;
    bus.cmd = '0;
    o_next  = i_state;
    o_dact  = DEP_HOLD;
    case (i_state)
      ST_EXEC: begin
        bus.pc = PC_INC;
        case (bus.instr)
          OP_PINC: bus.cmd[CMD_PINC] = 1'b1;
          OP_PDEC: bus.cmd[CMD_PDEC] = 1'b1;
          OP_DINC: bus.cmd[CMD_DINC] = 1'b1;
          OP_DDEC: bus.cmd[CMD_DDEC] = 1'b1;
          // I/O strobes stay up and the PC holds until the device responds
          OP_OUT: begin
            bus.cmd[CMD_OUT] = 1'b1;
            bus.pc           = bus.ioready ? PC_INC : PC_HOLD;
          end
          OP_IN: begin
            bus.cmd[CMD_IN] = 1'b1;
            bus.pc          = bus.ioready ? PC_INC : PC_HOLD;
          end
          OP_LOPEN: begin
            if (bus.zeroflag) begin
              o_dact = DEP_CLR;
              o_next = ST_SKIP_FWD;
            end
          end
          OP_LCLOSE: begin
            if (!bus.zeroflag) begin
              bus.pc = PC_DEC;
              o_dact = DEP_CLR;
              o_next = ST_SKIP_BACK;
            end
          end
`ifdef POTATO1_HALT_EN
          OP_HALT: begin
            bus.pc = PC_HOLD;
            o_next = ST_HALT;
          end
`endif
          default: ;
        endcase
      end
      ST_SKIP_FWD: begin
        bus.pc = PC_INC;
        if (bus.instr == OP_LOPEN) begin
          o_dact = DEP_INC;
        end else if (bus.instr == OP_LCLOSE) begin
          if (i_depth_zero) o_next = ST_EXEC;
          else              o_dact = DEP_DEC;
        end
      end
      ST_SKIP_BACK: begin
        bus.pc = PC_DEC;
        if (bus.instr == OP_LCLOSE) begin
          o_dact = DEP_INC;
        end else if (bus.instr == OP_LOPEN) begin
          // matching "[" found: step past it and resume
          if (i_depth_zero) begin
            bus.pc = PC_INC;
            o_next = ST_EXEC;
          end else begin
            o_dact = DEP_DEC;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/potato1_main.sv
// Potato-1 control unit top: io_in/io_out tile mapping, FSM state and loop-depth registers.
// Optional HALT opcode enabled by POTATO1_HALT_EN.
module potato1_main
  import potato1_pkg::*;
#(
  parameter int DEPTH_W = DEPTH_W_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic                w_clk;
  logic                w_rst;
  state_t              r_state;
  state_t              w_next;
  dep_act_t            w_dact;
  logic [DEPTH_W-1:0]  r_depth;

  potato1_if u_bus ();

  assign w_clk          = io_in[0];
  assign w_rst          = io_in[1];
  assign u_bus.ioready  = io_in[2];
  assign u_bus.zeroflag = io_in[3];
  assign u_bus.instr    = io_in[7:4];

  potato1_decoder u_dec (
    .i_state      (r_state),
    .i_depth_zero (r_depth == '0),
    .bus          (u_bus),
    .o_next       (w_next),
    .o_dact       (w_dact)
  );

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= ST_EXEC;
      r_depth <= '0;
    end else begin
      r_state <= w_next;
      case (w_dact)
        DEP_CLR: r_depth <= '0;
        // saturate rather than wrap on over-deep nesting
        DEP_INC: if (r_depth != '1) r_depth <= r_depth + DEPTH_W'(1);
        DEP_DEC: r_depth <= r_depth - DEPTH_W'(1);
        default: ;
      endcase
    end
  end

  // reset forces pc-clear with no strobes, without waiting for a clock
  assign io_out = w_rst ? {6'b0, PC_CLR} : {u_bus.cmd, u_bus.pc};

endmodule

// File: tb/tb_potato1_main.sv
// Scoreboard bench for potato1_main; expectations follow POTATO1_HALT_EN when defined.
module tb_potato1_main;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [7:0] io_in;
  logic [7:0] io_out;
  sb_t        sb[$];
  int         n_chk;
  int         n_pass;

  potato1_if bus ();

  assign io_in   = {bus.instr, bus.zeroflag, bus.ioready, rst, clk};
  assign bus.pc  = io_out[1:0];
  assign bus.cmd = io_out[7:2];

  potato1_main dut (.io_in(io_in), .io_out(io_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
  endtask

  // drive one instruction cycle and queue its expected io_out
  task automatic step(input string tag, input logic [3:0] op, input logic zf,
                      input logic ior, input logic [7:0] exp);
    sb_t e;
    bus.instr    = op;
    bus.zeroflag = zf;
    bus.ioready  = ior;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.tag, {bus.cmd, bus.pc}, e.exp);
    end
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.instr = 4'h0;
    bus.zeroflag = 1'b0;
    bus.ioready = 1'b0;
    @(posedge clk);
    #1;

    step("rst_hold", 4'h3, 1'b0, 1'b0, 8'h03);
    rst = 1'b0;
    step("dinc",  4'h3, 1'b0, 1'b0, 8'h11);
    step("pinc",  4'h1, 1'b0, 1'b0, 8'h05);
    step("pdec",  4'h2, 1'b0, 1'b0, 8'h09);
    step("ddec",  4'h4, 1'b0, 1'b0, 8'h21);
    step("nop0",  4'h0, 1'b0, 1'b0, 8'h01);
    step("nop9",  4'h9, 1'b1, 1'b1, 8'h01);
    step("nopE",  4'hE, 1'b0, 1'b0, 8'h01);

    for (int i = 0; i < 3; i++) step("out_wait", 4'h5, 1'b0, 1'b0, 8'h40);
    step("out_rdy", 4'h5, 1'b0, 1'b1, 8'h41);
    step("in_wait", 4'h6, 1'b0, 1'b0, 8'h80);
    step("in_rdy",  4'h6, 1'b0, 1'b1, 8'h81);

    // "[ + [ ] ]" skipped forward, then EXEC resumes
    step("sf_open",  4'h7, 1'b1, 1'b0, 8'h01);
    step("sf_plus",  4'h3, 1'b1, 1'b0, 8'h01);
    step("sf_in",    4'h7, 1'b0, 1'b0, 8'h01);
    step("sf_cl1",   4'h8, 1'b0, 1'b0, 8'h01);
    step("sf_cl0",   4'h8, 1'b0, 1'b0, 8'h01);
    step("sf_resume", 4'h3, 1'b0, 1'b0, 8'h11);

    // "[ [ ] - ]" run forward, then walk back to the outer "["
    step("sb_o",    4'h7, 1'b0, 1'b0, 8'h01);
    step("sb_i",    4'h7, 1'b0, 1'b0, 8'h01);
    step("sb_ic",   4'h8, 1'b1, 1'b0, 8'h01);
    step("sb_dec",  4'h4, 1'b0, 1'b0, 8'h21);
    step("sb_oc",   4'h8, 1'b0, 1'b0, 8'h02);
    step("sb_w_m",  4'h4, 1'b0, 1'b0, 8'h02);
    step("sb_w_ic", 4'h8, 1'b1, 1'b0, 8'h02);
    step("sb_w_i",  4'h7, 1'b1, 1'b0, 8'h02);
    step("sb_w_o",  4'h7, 1'b1, 1'b0, 8'h01);
    step("sb_resume", 4'h1, 1'b0, 1'b0, 8'h05);

    // 17 opens saturate depth at 15; 15 closes unwind, the 16th exits
    step("sat_enter", 4'h7, 1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 17; i++) step("sat_open", 4'h7, 1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 16; i++) step("sat_close", 4'h8, 1'b0, 1'b0, 8'h01);
    step("sat_resume", 4'h3, 1'b0, 1'b0, 8'h11);

    // reset while walking back
    step("rb_enter", 4'h8, 1'b0, 1'b0, 8'h02);
    step("rb_walk",  4'h0, 1'b0, 1'b0, 8'h02);
    rst = 1'b1;
    #1;
    chk("rst_async", io_out, 8'h03);
    @(posedge clk);
    #1;
    step("rst_mid", 4'h8, 1'b0, 1'b0, 8'h03);
    rst = 1'b0;
    step("rb_resume", 4'h3, 1'b0, 1'b0, 8'h11);

`ifdef POTATO1_HALT_EN
    step("halt",    4'hF, 1'b0, 1'b0, 8'h00);
    step("halt_d",  4'h3, 1'b0, 1'b0, 8'h00);
    step("halt_io", 4'h5, 1'b0, 1'b1, 8'h00);
    step("halt_lp", 4'h8, 1'b0, 1'b0, 8'h00);
`else
    step("halt",    4'hF, 1'b0, 1'b0, 8'h01);
    step("halt_d",  4'h3, 1'b0, 1'b0, 8'h11);
    step("halt_io", 4'h5, 1'b0, 1'b1, 8'h41);
    step("halt_lp", 4'h8, 1'b0, 1'b0, 8'h02);
`endif
    rst = 1'b1;
    step("rst_end", 4'h3, 1'b0, 1'b0, 8'h03);
    rst = 1'b0;
    step("post_rst", 4'h2, 1'b0, 1'b0, 8'h09);

    repeat (2) @(negedge clk);
    chk("sb_drain", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/potato1_main.md
# potato1_main

Control unit of the Potato-1 4-bit Brainfuck-style processor, packaged for an 8-in/8-out tile.
- It consumes one 4-bit opcode per cycle from external program memory and drives external program-counter control plus six datapath strobes.
- A cell-zero flag and an I/O-ready handshake come back from the external datapath.
- All memory, pointer and data registers live outside this block; only the sequencing FSM and the loop-nesting counter live inside.

## Interface
- DEPTH_W, 4, width of the internal loop-nesting counter.
- io_in[0]  input  1  clock; all state updates on the rising edge.
- io_in[1]  input  1  reset; asynchronous, active-high.
- io_in[2]  input  1  ioready; external I/O device accepted or supplied data this cycle.
- io_in[3]  input  1  zeroflag; the current data cell equals zero.
- io_in[7:4]  input  4  instruction; opcode at the current external PC.
- io_out[1:0]  output  2  pc control.
  - 00 hold, 01 increment, 10 decrement, 11 clear to 0.
- io_out[7:2]  output  6  command strobes, one bit per action; bits listed as command[k] = io_out[k+2].
  - [0] ptr_inc, [1] ptr_dec, [2] data_inc, [3] data_dec, [4] out_strobe, [5] in_strobe.

## Operation
- Opcodes:
  - 0 NOP; 1 ptr_inc; 2 ptr_dec; 3 data_inc; 4 data_dec; 5 output; 6 input.
  - 7 loop-open "["; 8 loop-close "]"; F HALT.
  - 9–E behave as NOP.
- States: EXEC, SKIP_FWD, SKIP_BACK, HALT. Register depth is DEPTH_W bits.
- EXEC:
  - NOP: pc=01, command=0.
  - Opcodes 1–4: the matching strobe is high for exactly this cycle, pc=01.
  - 5/6: out_strobe/in_strobe is high. pc=01 if ioready=1, else pc=00. The strobe stays high every cycle until ioready.
  - "[": zeroflag=0 gives pc=01. zeroflag=1 gives pc=01, depth<=0, next state SKIP_FWD.
  - "]": zeroflag=1 gives pc=01. zeroflag=0 gives pc=10, depth<=0, next state SKIP_BACK.
- SKIP_FWD: command=0, pc=01.
  - "[" increments depth.
  - "]" with depth=0 returns to EXEC; otherwise depth decrements.
- SKIP_BACK: command=0.
  - "]" increments depth; pc=10.
  - "[" with depth=0 gives pc=01 and returns to EXEC, resuming just past the matching "[".
  - "[" with depth≠0 decrements depth; pc=10.
  - Any other opcode: pc=10.
- HALT: pc=00, command=0. The only exit is reset.
- depth saturates at 2^DEPTH_W−1 and never wraps. Nesting deeper than that is unsupported.
- No more than one command bit is ever high at a time.

## Timing
- io_out is combinational from the registered state and the current io_in. The external PC and datapath act on the next rising edge.
- Reset asserted: state=EXEC, depth=0, io_out = pc 11, command 000000, immediately and independently of the clock.
- First edge after reset deassertion executes the opcode at PC 0.
- Each non-I/O instruction and each skip step takes one cycle. An I/O instruction takes 1 + (cycles until ioready=1).
- If reset is asserted mid-skip or mid-I/O wait, the skip or wait is abandoned; no state is retained.

## Configuration
- POTATO1_HALT_EN defined: opcode F enters HALT.
- POTATO1_HALT_EN undefined: opcode F is a NOP and the HALT state does not exist.

## Structure
- Shared package potato1_pkg holds:
  - opcode constants;
  - pc-control codes;
  - command bit indices;
  - the state enum typedef.
- One sub-module, potato1_decoder: combinational mapping from (state, instruction, zeroflag, ioready, depth==0) to pc, command, next state and depth action.
- The top holds the state and depth registers and the io_in/io_out bit mapping.

## Test plan
- Reset held high → io_out=0x03. After release with instruction=3 → io_out=0x11 (data_inc, pc=01) for one cycle.
- Instruction=5 with ioready=0 for 3 cycles, then 1 → io_out=0x40 for 3 cycles, then 0x41.
- Program "[ + [ ] ]" with zeroflag=1 → pc=01 every cycle, command=0 throughout the skip. Opcode 3 emits no strobe. EXEC is resumed after the outer "]".
- Program "[ [ ] - ]": execute to the final "]" with zeroflag=0 → pc=10 while walking back, skipping the inner pair, then pc=01 on the first "[".
- Opcode F with POTATO1_HALT_EN → io_out=0x00 indefinitely. Without the macro → io_out=0x01.
- Reset asserted during SKIP_BACK → io_out=0x03 immediately. After release, normal execution proceeds from EXEC.
